cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 block for the five-stage MIPS pipeline. It sits at the M stage and owns SR (12), Cause (13), EPC (14) and PRId (15).
- It decides when an exception or interrupt is taken and drives the request and return-address side of the fetch unit:
  - Req redirects fetch to the handler.
  - EPCOut supplies the eret return PC.
- It also serves mfc0 reads and mtc0 writes.

---
 rtl/cp0_exc_ctrl_pkg.sv | 51 +++++
 rtl/cp0_req_arb.sv | 41 ++++
 rtl/cp0_exc_ctrl.sv | 115 +++++++++++
 tb/tb_cp0_exc_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register indices, field positions, exception codes
// and helpers that assemble the architectural register images.
package cpu_defs;

  localparam logic [4:0] SR_IDX    = 5'd12;
  localparam logic [4:0] CAUSE_IDX = 5'd13;
  localparam logic [4:0] EPC_IDX   = 5'd14;
  localparam logic [4:0] PRID_IDX  = 5'd15;

  localparam int SR_IM_MSB     = 15;
  localparam int SR_IM_LSB     = 10;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IE_BIT     = 0;
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_EXC_LSB = 2;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  function automatic logic [31:0] sr_image(input logic [5:0] im, input logic exl,
                                           input logic ie);
    logic [31:0] w;
    w = '0;
    w[SR_IM_MSB:SR_IM_LSB] = im;
    w[SR_EXL_BIT]          = exl;
    w[SR_IE_BIT]           = ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_image(input logic bd, input logic [5:0] ip,
                                              input logic [4:0] exc);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD_BIT]                = bd;
    w[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
    w[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Exception/interrupt request arbitration and the victim return address
// (EPC) computation for the M-stage CP0.
module cp0_req_arb
  import cpu_defs::*;
(
  input  logic [5:0]  hw_int,
  input  logic [5:0]  sr_im,
  input  logic        sr_ie,
  input  logic        sr_exl,
  input  logic [4:0]  exc_code_in,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  output logic        req,
  output logic [4:0]  exc_code,
  output logic [31:0] epc_val
);

  logic [5:0]  pend;
  logic        int_req;
  logic        exc_req;
  logic [31:0] vpc_aligned;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_int_mask
      assign pend[gi] = hw_int[gi] & sr_im[gi];
    end
  endgenerate

  // EXL masks everything, so a handler is never re-entered.
  assign int_req = (|pend) & sr_ie & ~sr_exl;
  assign exc_req = (exc_code_in != EXC_INT) & ~sr_exl;
  assign req     = int_req | exc_req;

  assign exc_code = int_req ? EXC_INT : exc_code_in;

  // A delay-slot victim restarts at its branch; 32-bit wraparound is intended.
  assign vpc_aligned = vpc & 32'hFFFF_FFFC;
  assign epc_val     = bd_in ? (vpc_aligned - 32'd4) : vpc_aligned;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC/PRId registers, mfc0/mtc0
// access and the exception request that redirects fetch.
module cp0_exc_ctrl
  import cpu_defs::*;
#(
  parameter logic [31:0] PRID    = 32'h5072_6F37,
  parameter logic [31:0] EPC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  sr_im_reg, sr_im_next;
  logic        sr_exl_reg, sr_exl_next;
  logic        sr_ie_reg, sr_ie_next;
  logic        cause_bd_reg, cause_bd_next;
  logic [5:0]  cause_ip_reg, cause_ip_next;
  logic [4:0]  cause_exc_reg, cause_exc_next;
  logic [31:0] epc_reg, epc_next;

  logic        req_raw;
  logic [4:0]  arb_exc_code;
  logic [31:0] arb_epc;

  cp0_req_arb u_req_arb (
    .hw_int      (HWInt),
    .sr_im       (sr_im_reg),
    .sr_ie       (sr_ie_reg),
    .sr_exl      (sr_exl_reg),
    .exc_code_in (ExcCodeIn),
    .vpc         (VPC),
    .bd_in       (BDIn),
    .req         (req_raw),
    .exc_code    (arb_exc_code),
    .epc_val     (arb_epc)
  );

  // Registers are held while reset is low, but the request is combinational
  // and must be suppressed explicitly.
  assign Req    = req_raw & reset;
  assign EPCOut = epc_reg;

  always_comb begin
    sr_im_next     = sr_im_reg;
    sr_exl_next    = sr_exl_reg;
    sr_ie_next     = sr_ie_reg;
    cause_bd_next  = cause_bd_reg;
    cause_ip_next  = HWInt;
    cause_exc_next = cause_exc_reg;
    epc_next       = epc_reg;

    if (req_raw) begin
      sr_exl_next    = 1'b1;
      cause_exc_next = arb_exc_code;
      cause_bd_next  = BDIn;
      epc_next       = arb_epc;
    end else begin
      if (EXLClr) sr_exl_next = 1'b0;
      // During eret an SR write still lands, but EXL must come out cleared.
      if (en) begin
        case (CP0Add)
          SR_IDX: begin
            sr_im_next  = CP0In[SR_IM_MSB:SR_IM_LSB];
            sr_exl_next = CP0In[SR_EXL_BIT] & ~EXLClr;
            sr_ie_next  = CP0In[SR_IE_BIT];
          end
          EPC_IDX: epc_next = CP0In;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im_reg     <= '0;
      sr_exl_reg    <= 1'b0;
      sr_ie_reg     <= 1'b0;
      cause_bd_reg  <= 1'b0;
      cause_ip_reg  <= '0;
      cause_exc_reg <= '0;
      epc_reg       <= EPC_RST;
    end else begin
      sr_im_reg     <= sr_im_next;
      sr_exl_reg    <= sr_exl_next;
      sr_ie_reg     <= sr_ie_next;
      cause_bd_reg  <= cause_bd_next;
      cause_ip_reg  <= cause_ip_next;
      cause_exc_reg <= cause_exc_next;
      epc_reg       <= epc_next;
    end
  end

  always_comb begin
    case (CP0Add)
      SR_IDX:    CP0Out = sr_image(sr_im_reg, sr_exl_reg, sr_ie_reg);
      CAUSE_IDX: CP0Out = cause_image(cause_bd_reg, cause_ip_reg, cause_exc_reg);
      EPC_IDX:   CP0Out = epc_reg;
      PRID_IDX:  CP0Out = PRID;
      default:   CP0Out = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus randomized
// traffic checked against a word-level CP0 reference model.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID_V = 32'h5072_6F37;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: whole architectural register words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_ctrl #(.PRID(PRID_V), .EPC_RST(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
    .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic bit m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_exc();
    return (ExcCodeIn != 5'd0) && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
  endtask

  task automatic drive(input logic e, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input logic bd, input logic [4:0] x,
                       input logic [5:0] h, input logic clr);
    en = e; CP0Add = a; CP0In = d; VPC = pc; BDIn = bd; ExcCodeIn = x;
    HWInt = h; EXLClr = clr;
  endtask

  // Apply one rising edge to the model with the current inputs.
  task automatic cycle();
    logic [31:0] s, c, e;
    s = m_sr; c = m_cause; e = m_epc;
    c[15:10] = HWInt;
    if (m_int() || m_exc()) begin
      s[1] = 1'b1;
      c[6:2] = m_int() ? 5'd0 : ExcCodeIn;
      c[31] = BDIn;
      e = (VPC & ~32'd3) - (BDIn ? 32'd4 : 32'd0);
    end else if (EXLClr) begin
      s[1] = 1'b0;
      if (en && CP0Add == 5'd12) s = CP0In & 32'h0000_FC01;
      if (en && CP0Add == 5'd14) e = CP0In;
    end else if (en) begin
      if (CP0Add == 5'd12) s = CP0In & 32'h0000_FC03;
      if (CP0Add == 5'd14) e = CP0In;
    end
    @(posedge clk); #1;
    m_sr = s; m_cause = c; m_epc = e;
  endtask

  task automatic eret();
    drive(0, 0, 0, 0, 0, 0, 0, 1); @(negedge clk); cycle();
  endtask

  task automatic test_reset();
    logic [4:0] idx;
    #2;
    for (int i = 0; i < 3; i++) begin
      idx = 5'(12 + i); CP0Add = idx; #1;
      n_cmp++; if (CP0Out !== 32'h0) begin n_bad++; $display("FAIL reset_state reg%0d got %h expected %h", idx, CP0Out, 32'h0); end
    end
    ExcCodeIn = 5'd4; #1;
    n_cmp++; if (Req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b expected 0", Req); end
    ExcCodeIn = 5'd0; reset = 1'b1; model_reset();
    @(posedge clk); #1;
    drive(1, 12, 32'h0000_FC03, 0, 0, 0, 0, 0); @(negedge clk); cycle();
    en = 1'b0; #1;
    n_cmp++; if (CP0Out !== 32'h0000_FC03) begin n_bad++; $display("FAIL sr_write got %h expected %h", CP0Out, 32'h0000_FC03); end
    reset = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      idx = 5'(12 + i); CP0Add = idx; #1;
      n_cmp++; if (CP0Out !== 32'h0) begin n_bad++; $display("FAIL async_reset reg%0d got %h expected %h", idx, CP0Out, 32'h0); end
    end
    ExcCodeIn = 5'd4; #1;
    n_cmp++; if (Req !== 1'b0) begin n_bad++; $display("FAIL async_reset_req got %b expected 0", Req); end
    n_cmp++; if (EPCOut !== 32'h0) begin n_bad++; $display("FAIL async_reset_epc got %h expected %h", EPCOut, 32'h0); end
    ExcCodeIn = 5'd0; reset = 1'b1; model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_exception();
    drive(0, 14, 0, 32'h0000_3010, 0, 10, 0, 0); @(negedge clk);
    n_cmp++; if (Req !== 1'b1) begin n_bad++; $display("FAIL exc_req got %b expected 1", Req); end
    cycle();
    CP0Add = 14; #1;
    n_cmp++; if (CP0Out !== 32'h0000_3010) begin n_bad++; $display("FAIL exc_epc got %h expected %h", CP0Out, 32'h0000_3010); end
    CP0Add = 13; #1;
    n_cmp++; if (CP0Out !== 32'h0000_0028) begin n_bad++; $display("FAIL exc_cause got %h expected %h", CP0Out, 32'h0000_0028); end
    CP0Add = 12; #1;
    n_cmp++; if (CP0Out !== 32'h0000_0002) begin n_bad++; $display("FAIL exc_sr got %h expected %h", CP0Out, 32'h0000_0002); end
    eret();
  endtask

  task automatic test_delay_slot();
    drive(0, 13, 0, 32'h0000_3024, 1, 12, 0, 0); @(negedge clk);
    n_cmp++; if (Req !== 1'b1) begin n_bad++; $display("FAIL ds_req got %b expected 1", Req); end
    cycle(); #1;
    n_cmp++; if (CP0Out !== 32'h8000_0030) begin n_bad++; $display("FAIL ds_cause got %h expected %h", CP0Out, 32'h8000_0030); end
    n_cmp++; if (EPCOut !== 32'h0000_3020) begin n_bad++; $display("FAIL ds_epc got %h expected %h", EPCOut, 32'h0000_3020); end
    eret();
    drive(0, 14, 0, 32'h0000_0000, 1, 8, 0, 0); @(negedge clk); cycle(); #1;
    n_cmp++; if (CP0Out !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL ds_wrap got %h expected %h", CP0Out, 32'hFFFF_FFFC); end
    eret();
    drive(0, 14, 0, 32'h0000_3027, 0, 5, 0, 0); @(negedge clk); cycle(); #1;
    n_cmp++; if (CP0Out !== 32'h0000_3024) begin n_bad++; $display("FAIL epc_align got %h expected %h", CP0Out, 32'h0000_3024); end
    eret();
  endtask

  task automatic test_interrupt();
    drive(1, 12, 32'h0000_0401, 0, 0, 0, 0, 0); @(negedge clk); cycle();
    drive(0, 13, 0, 32'h0000_3100, 0, 0, 6'b000001, 0); @(negedge clk);
    n_cmp++; if (Req !== 1'b1) begin n_bad++; $display("FAIL int_req got %b expected 1", Req); end
    cycle(); #1;
    n_cmp++; if (CP0Out !== 32'h0000_0400) begin n_bad++; $display("FAIL int_cause got %h expected %h", CP0Out, 32'h0000_0400); end
    CP0Add = 12; #1;
    n_cmp++; if (CP0Out !== 32'h0000_0403) begin n_bad++; $display("FAIL int_sr got %h expected %h", CP0Out, 32'h0000_0403); end
    eret();
    drive(0, 13, 0, 32'h0000_3200, 0, 12, 6'b000001, 0); @(negedge clk);
    n_cmp++; if (Req !== 1'b1) begin n_bad++; $display("FAIL prio_req got %b expected 1", Req); end
    cycle(); #1;
    n_cmp++; if (CP0Out !== 32'h0000_0400) begin n_bad++; $display("FAIL prio_cause got %h expected %h", CP0Out, 32'h0000_0400); end
    eret();
    drive(1, 12, 32'h0000_0400, 0, 0, 0, 0, 0); @(negedge clk); cycle();
    drive(0, 13, 0, 32'h0000_3300, 0, 0, 6'b000001, 0); @(negedge clk);
    n_cmp++; if (Req !== 1'b0) begin n_bad++; $display("FAIL ie_off_req got %b expected 0", Req); end
    cycle(); #1;
    n_cmp++; if (CP0Out !== 32'h0000_0400) begin n_bad++; $display("FAIL ie_off_cause got %h expected %h", CP0Out, 32'h0000_0400); end
    drive(0, 13, 0, 0, 0, 0, 0, 0); @(negedge clk); cycle();
  endtask

  task automatic test_collision();
    drive(1, 14, 32'hDEAD_BEEC, 32'h0000_3040, 0, 4, 0, 0); @(negedge clk);
    n_cmp++; if (Req !== 1'b1) begin n_bad++; $display("FAIL coll_req got %b expected 1", Req); end
    cycle(); en = 1'b0; #1;
    n_cmp++; if (CP0Out !== 32'h0000_3040) begin n_bad++; $display("FAIL coll_epc got %h expected %h", CP0Out, 32'h0000_3040); end
    drive(0, 13, 0, 32'h0000_3050, 0, 4, 0, 0); @(negedge clk);
    n_cmp++; if (Req !== 1'b0) begin n_bad++; $display("FAIL exl_mask_req got %b expected 0", Req); end
    cycle(); #1;
    n_cmp++; if (EPCOut !== 32'h0000_3040) begin n_bad++; $display("FAIL exl_mask_epc got %h expected %h", EPCOut, 32'h0000_3040); end
    n_cmp++; if (CP0Out !== 32'h0000_0010) begin n_bad++; $display("FAIL exl_mask_cause got %h expected %h", CP0Out, 32'h0000_0010); end
  endtask

  task automatic test_eret();
    drive(1, 12, 32'h0000_0403, 0, 0, 0, 0, 1); @(negedge clk); cycle(); en = 1'b0; #1;
    n_cmp++; if (CP0Out !== 32'h0000_0401) begin n_bad++; $display("FAIL eret_sr got %h expected %h", CP0Out, 32'h0000_0401); end
    CP0Add = 15; #1;
    n_cmp++; if (CP0Out !== PRID_V) begin n_bad++; $display("FAIL prid got %h expected %h", CP0Out, PRID_V); end
    CP0Add = 20; #1;
    n_cmp++; if (CP0Out !== 32'h0) begin n_bad++; $display("FAIL bad_index got %h expected %h", CP0Out, 32'h0); end
    drive(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0); @(negedge clk); cycle(); en = 1'b0; #1;
    n_cmp++; if (CP0Out !== 32'h0000_0010) begin n_bad++; $display("FAIL cause_ro got %h expected %h", CP0Out, 32'h0000_0010); end
    drive(1, 14, 32'h1234_5678, 0, 0, 0, 0, 0); @(negedge clk);
    n_cmp++; if (EPCOut !== 32'h0000_3040) begin n_bad++; $display("FAIL no_bypass got %h expected %h", EPCOut, 32'h0000_3040); end
    cycle(); en = 1'b0; #1;
    n_cmp++; if (EPCOut !== 32'h1234_5678) begin n_bad++; $display("FAIL epc_write got %h expected %h", EPCOut, 32'h1234_5678); end
  endtask

  task automatic test_random();
    logic        e, bd, clr, exp_req;
    logic [4:0]  a, x;
    logic [5:0]  h;
    int          r;
    for (int i = 0; i < 400; i++) begin
      e   = ($urandom_range(3) == 0);
      r   = $urandom_range(5);
      a   = (r < 4) ? 5'(12 + r) : 5'($urandom_range(31));
      bd  = $urandom_range(1) == 1;
      x   = ($urandom_range(2) == 0) ? 5'($urandom_range(31)) : 5'd0;
      h   = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'd0;
      clr = ($urandom_range(4) == 0);
      drive(e, a, $urandom, $urandom, bd, x, h, clr);
      @(negedge clk);
      exp_req = m_int() || m_exc();
      n_cmp++; if (Req !== exp_req) begin n_bad++; $display("FAIL rand_req[%0d] got %b expected %b", i, Req, exp_req); end
      n_cmp++; if (CP0Out !== m_read(a)) begin n_bad++; $display("FAIL rand_read[%0d] reg%0d got %h expected %h", i, a, CP0Out, m_read(a)); end
      n_cmp++; if (EPCOut !== m_epc) begin n_bad++; $display("FAIL rand_epc[%0d] got %h expected %h", i, EPCOut, m_epc); end
      cycle();
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_exception();
    test_delay_slot();
    test_interrupt();
    test_collision();
    test_eret();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
